// File: rtl/program_counter_stack_if.sv
// Control strobes and status of the fetch-stage program counter with return-address stack.
// The control unit drives through master; the PC block receives through slave.
interface program_counter_stack_if #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned SP_W = $clog2(DEPTH + 1);

   logic             ld_pc;
   logic             inc_pc;
   logic             call;
   logic             ret;
   logic             skip;
   logic [WIDTH-1:0] pc_in;
   logic [WIDTH-1:0] pc_out;
   logic [SP_W-1:0]  sp_out;
   logic             stk_empty;
   logic             stk_full;
   logic             stk_err;

   modport master (
      output ld_pc, inc_pc, call, ret, skip, pc_in,
      input  pc_out, sp_out, stk_empty, stk_full, stk_err
   );

   modport slave (
      input  ld_pc, inc_pc, call, ret, skip, pc_in,
      output pc_out, sp_out, stk_empty, stk_full, stk_err
   );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack and sticky overflow/underflow flag.
// Optional feature: define PC_SKIP_EN to honour the skip (PC += 2) strobe.
module program_counter_stack #(
   parameter int unsigned     WIDTH        = 5,
   parameter int unsigned     DEPTH        = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input logic                     clk,
   input logic                     rst,
   program_counter_stack_if.slave  bus
);
   localparam int unsigned SP_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      ActHold,
      ActInc,
      ActSkip,
      ActLoad,
      ActCall,
      ActRet
   } action_e;

   action_e          act;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [SP_W-1:0]  sp_q, sp_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [SP_W-1:0]  sp_dec;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] pop_idx;
   logic [WIDTH-1:0] ret_addr;
   logic             push;

`ifndef PC_SKIP_EN
   logic unused_skip;
   assign unused_skip = bus.skip;
`endif

   assign sp_dec   = sp_q - SP_W'(1);
   assign push_idx = sp_q[IDX_W-1:0];
   assign pop_idx  = sp_dec[IDX_W-1:0];
   assign ret_addr = pc_q + WIDTH'(1);

   // Fixed priority: ret > call > ld_pc > skip > inc_pc > hold (rst handled in the registers).
   always_comb begin
      act = ActHold;
      if (bus.ret) begin
         act = ActRet;
      end else if (bus.call) begin
         act = ActCall;
      end else if (bus.ld_pc) begin
         act = ActLoad;
`ifdef PC_SKIP_EN
      end else if (bus.skip) begin
         act = ActSkip;
`endif
      end else if (bus.inc_pc) begin
         act = ActInc;
      end
   end

   always_comb begin
      pc_d  = pc_q;
      sp_d  = sp_q;
      err_d = err_q;
      push  = 1'b0;
      unique case (act)
         ActRet: begin
            if (sp_q != '0) begin
               pc_d = stack_q[pop_idx];
               sp_d = sp_dec;
            end else begin
               err_d = 1'b1;
            end
         end
         ActCall: begin
            if (sp_q != SP_W'(DEPTH)) begin
               push = 1'b1;
               pc_d = bus.pc_in;
               sp_d = sp_q + SP_W'(1);
            end else begin
               err_d = 1'b1;
            end
         end
         ActLoad: pc_d = bus.pc_in;
         ActSkip: pc_d = pc_q + WIDTH'(2);
         ActInc:  pc_d = ret_addr;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Entries above sp are don't-care, so the storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         stack_q[push_idx] <= ret_addr;
      end
   end

   assign bus.pc_out    = pc_q;
   assign bus.sp_out    = sp_q;
   assign bus.stk_empty = (sp_q == '0);
   assign bus.stk_full  = (sp_q == SP_W'(DEPTH));
   assign bus.stk_err   = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Table-driven and randomized checks of program_counter_stack against a queue-based model.
module tb_program_counter_stack;
   localparam int unsigned WIDTH = 5;
   localparam int unsigned DEPTH = 4;
`ifdef PC_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   typedef struct {
      logic       rst, ld, inc, call, ret, skip;
      logic [4:0] pc_in;
      logic [4:0] exp_pc;
      logic [2:0] exp_sp;
      logic       exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: PC as an integer, stack as a queue.
   int   m_pc;
   int   m_stk[$];
   bit   m_err;

   program_counter_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   program_counter_stack #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .RESET_VECTOR(5'd0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, ld, inc, cl, rt, sk, input int pin, epc, esp, input logic eerr);
      vec_t v;
      v.rst = r; v.ld = ld; v.inc = inc; v.call = cl; v.ret = rt; v.skip = sk;
      v.pc_in = 5'(pin); v.exp_pc = 5'(epc); v.exp_sp = 3'(esp); v.exp_err = eerr;
      vecs.push_back(v);
   endtask

   task automatic model_step(input logic r, ld, inc, cl, rt, sk, input logic [4:0] pin);
      if (r) begin
         m_pc = 0; m_stk.delete(); m_err = 1'b0;
      end else if (rt) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else m_err = 1'b1;
      end else if (cl) begin
         if (m_stk.size() < DEPTH) begin
            m_stk.push_back((m_pc + 1) % 32);
            m_pc = int'(pin);
         end else m_err = 1'b1;
      end else if (ld) m_pc = int'(pin);
      else if (sk && SKIP_EN) m_pc = (m_pc + 2) % 32;
      else if (inc) m_pc = (m_pc + 1) % 32;
   endtask

   // One clock: drive, let the edge pass, sample 1 time unit later, update model, compare.
   task automatic cycle(input logic r, ld, inc, cl, rt, sk, input logic [4:0] pin,
                        input string tag);
      logic [10:0] act, exp;
      rst = r; bus.ld_pc = ld; bus.inc_pc = inc; bus.call = cl; bus.ret = rt;
      bus.skip = sk; bus.pc_in = pin;
      @(posedge clk);
      #1;
      model_step(r, ld, inc, cl, rt, sk, pin);
      act = {bus.pc_out, bus.sp_out, bus.stk_empty, bus.stk_full, bus.stk_err};
      exp = {5'(m_pc), 3'(m_stk.size()), m_stk.size() == 0, m_stk.size() == DEPTH, m_err};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL model %s: got pc=%0d sp=%0d e=%b f=%b err=%b, need pc=%0d sp=%0d e=%b f=%b err=%b",
                  tag, act[10:6], act[5:3], act[2], act[1], act[0],
                  exp[10:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      rst = 1'b1; bus.ld_pc = 0; bus.inc_pc = 0; bus.call = 0; bus.ret = 0;
      bus.skip = 0; bus.pc_in = '0;

      //   rst ld inc cl rt sk pc_in  pc  sp err
      add(1, 0, 0, 0, 0, 0,  0,   0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  0,   0, 0, 0);
      add(0, 0, 1, 0, 0, 0,  0,   1, 0, 0);
      add(0, 0, 1, 0, 0, 0,  0,   2, 0, 0);
      add(0, 0, 1, 0, 0, 0,  0,   3, 0, 0);
      add(0, 0, 0, 1, 0, 0, 20,  20, 1, 0);
      add(0, 0, 1, 0, 0, 0,  0,  21, 1, 0);
      add(0, 0, 0, 0, 1, 0,  0,   4, 0, 0);
      add(0, 1, 0, 0, 0, 0, 31,  31, 0, 0);
      add(0, 0, 1, 0, 0, 0,  0,   0, 0, 0);
      add(0, 1, 1, 0, 0, 0,  7,   7, 0, 0);
      add(0, 1, 0, 0, 0, 0,  0,   0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 10,  10, 1, 0);
      add(0, 0, 0, 1, 0, 0, 11,  11, 2, 0);
      add(0, 0, 0, 1, 0, 0, 12,  12, 3, 0);
      add(0, 0, 0, 1, 0, 0, 13,  13, 4, 0);
      add(0, 0, 0, 1, 0, 0, 25,  13, 4, 1);
      add(0, 0, 0, 0, 1, 0,  0,  13, 3, 1);
      add(0, 0, 0, 0, 1, 0,  0,  12, 2, 1);
      add(0, 0, 0, 0, 1, 0,  0,  11, 1, 1);
      add(0, 0, 0, 0, 1, 0,  0,   1, 0, 1);
      add(0, 0, 0, 0, 1, 0,  0,   1, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0,   0, 0, 0);
      add(0, 0, 0, 1, 0, 0,  5,   5, 1, 0);
      add(0, 0, 0, 1, 1, 0,  9,   1, 0, 0);
      add(0, 1, 0, 0, 0, 0, 30,  30, 0, 0);
      add(0, 0, 0, 0, 0, 1,  0, SKIP_EN ? 0 : 30, 0, 0);
      add(0, 0, 1, 0, 0, 1,  0, SKIP_EN ? 2 : 31, 0, 0);
      add(0, 0, 0, 1, 0, 0,  3,   3, 1, 0);
      add(0, 0, 0, 1, 0, 0,  4,   4, 2, 0);
      add(1, 0, 0, 0, 0, 0,  0,   0, 0, 0);
      add(0, 0, 0, 0, 1, 0,  0,   0, 0, 1);
      add(0, 0, 0, 0, 0, 0,  0,   0, 0, 1);

      foreach (vecs[i]) begin
         vec_t v;
         logic [10:0] act, exp;
         v = vecs[i];
         cycle(v.rst, v.ld, v.inc, v.call, v.ret, v.skip, v.pc_in, $sformatf("vec%0d", i));
         act = {bus.pc_out, bus.sp_out, bus.stk_empty, bus.stk_full, bus.stk_err};
         exp = {v.exp_pc, v.exp_sp, v.exp_sp == 3'd0, v.exp_sp == 3'(DEPTH), v.exp_err};
         n_vec++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL table vec%0d: got pc=%0d sp=%0d e=%b f=%b err=%b, need pc=%0d sp=%0d e=%b f=%b err=%b",
                     i, act[10:6], act[5:3], act[2], act[1], act[0],
                     exp[10:6], exp[5:3], exp[2], exp[1], exp[0]);
         end
      end

      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 49) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
               $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised program counter with a hardware return-address stack, the next generation of the processor's 5-bit load/increment PC. It sits in the fetch stage, driven by the control unit's `ld_pc`/`inc_pc` strobes plus new `call`/`ret` strobes. Subroutine linkage therefore needs no register-file or memory traffic. Stack overflow and underflow are reported through status flags.

## Interface
Parameters:
- `WIDTH`, 5: PC and return-address width in bits.
- `DEPTH`, 4: number of return-stack entries (≥2).
- `RESET_VECTOR`, 0: PC value after reset (`WIDTH` bits).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_pc`  in  1  load `pc_in` into the PC.
- `inc_pc`  in  1  increment the PC by 1.
- `call`  in  1  push the return address and jump to `pc_in`.
- `ret`  in  1  pop the top entry into the PC.
- `skip`  in  1  advance the PC by 2. Present only with `PC_SKIP_EN`; otherwise ignored.
- `pc_in`  in  `WIDTH`  jump/load target.
- `pc_out`  out  `WIDTH`  current PC (registered).
- `sp_out`  out  `$clog2(DEPTH+1)`  number of valid stack entries (registered).
- `stk_empty`  out  1  `sp_out == 0`.
- `stk_full`  out  1  `sp_out == DEPTH`.
- `stk_err`  out  1  sticky overflow/underflow flag.

## Operation
- Exactly one action per cycle, chosen by fixed priority: `rst` > `ret` > `call` > `ld_pc` > `skip` > `inc_pc` > hold.
- `rst`:
  - `pc_out` = `RESET_VECTOR`, `sp_out` = 0, `stk_err` = 0.
  - Stack contents become don't-care; `stk_empty` = 1, `stk_full` = 0.
- `ret` with `sp_out > 0`: PC ← top entry; `sp_out` decrements.
- `ret` with `sp_out == 0` (underflow): PC holds, `sp_out` stays 0, `stk_err` ← 1.
- `call` with `sp_out < DEPTH`: push `pc_out + 1` (mod 2^WIDTH); PC ← `pc_in`; `sp_out` increments.
- `call` with `sp_out == DEPTH` (overflow): no push, PC holds, `stk_err` ← 1.
- `ld_pc`: PC ← `pc_in`. Stack untouched.
- `skip`: PC ← `pc_out + 2` (mod 2^WIDTH).
- `inc_pc`: PC ← `pc_out + 1` (mod 2^WIDTH).
- All PC arithmetic is truncated to `WIDTH` bits, so 2^WIDTH−1 + 1 wraps to 0.
- Stack is LIFO: a push writes `entry[sp]` and a pop reads `entry[sp-1]`.
- The `sp` counter saturates; it never wraps.
- `stk_err` is cleared only by `rst`. Once set, it does not block subsequent valid operations.

## Timing
- Every output is registered or decoded from registers. There is no combinational path from any input to any output.
- Single-cycle latency: inputs sampled at edge N are reflected on `pc_out`/`sp_out`/flags after edge N.
- Back-to-back `call`/`ret` on consecutive cycles is supported at full rate.
- Reset mid-operation (e.g. with `sp_out` = 2) discards the stack on that edge; no further pops are valid.
- Simultaneous `call` and `ret`: `ret` alone executes.
- Simultaneous `ld_pc` and `inc_pc`: the load executes.

## Configuration
- `PC_SKIP_EN` defined:
  - The `skip` input is honoured at the priority stated in Operation.
  - Used for conditional-skip instructions.
- `PC_SKIP_EN` undefined:
  - The `skip` port remains in the port list but is ignored entirely.
  - A cycle with `skip`=1 and `inc_pc`=1 increments by 1.
  - A cycle with `skip`=1 only holds the PC.

## Test plan
Test plan uses WIDTH=5, DEPTH=4, RESET_VECTOR=0.
- Reset/increment:
  - Hold `rst`=1 for 2 cycles → `pc_out`=0, `sp_out`=0, `stk_empty`=1, `stk_err`=0.
  - Release and hold `inc_pc`=1 for 3 cycles → `pc_out` steps 1, 2, 3.
- Load/wrap/priority:
  - `ld_pc` with `pc_in`=31 → 31.
  - Then `inc_pc` → 0.
  - Then `ld_pc`=`inc_pc`=1 with `pc_in`=7 → 7.
- Call/return:
  - At `pc_out`=3, `call` with `pc_in`=20 → `pc_out`=20, `sp_out`=1.
  - Then `inc_pc` → 21.
  - Then `ret` → `pc_out`=4, `sp_out`=0.
- Overflow and LIFO order:
  - From `pc_out`=0, apply 4 calls with targets 10, 11, 12, 13 → `stk_full`=1, `sp_out`=4.
  - A 5th call with target 25 → `pc_out` stays 13, `stk_err`=1.
  - 4 rets → `pc_out` returns 13, 12, 11, 1.
- Underflow and simultaneous strobes:
  - With `sp_out`=0, `ret` → PC holds and `stk_err`=1.
  - With `sp_out`=1, `call`+`ret` → only the pop occurs, `sp_out`=0.
- Skip and reset mid-operation:
  - With `PC_SKIP_EN`, at `pc_out`=30, `skip`=1 → 0.
  - With `PC_SKIP_EN`, `skip`+`inc_pc` → +2.
  - Without `PC_SKIP_EN`, `skip`+`inc_pc` → +1.
  - With `sp_out`=2, `rst` → `sp_out`=0, `pc_out`=0, `stk_err`=0.
